// File: rtl/step_dir_generator_pkg.sv
// Shared definitions for the step/direction generator: default widths,
// the direction setup time and the move-state encoding.
package step_dir_generator_pkg;

    localparam int CNT_W_DEF     = 16;
    localparam int PER_W_DEF     = 16;
    localparam int DIR_SETUP_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_HIGH  = 2'b10,
        ST_LOW   = 2'b11
    } state_e;

endpackage

// File: rtl/step_dir_generator_phase_timer.sv
// Down counter timing one phase (direction setup, CP high or CP low).
// The count is loaded with length-1, so the phase ends on the edge after the zero flag rises.
module step_dir_generator_phase_timer
    import step_dir_generator_pkg::*;
#(
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ena,
    input  logic [PER_W-1:0] load_val,
    output logic             zero
);

    logic [PER_W-1:0] cnt_r;

    // Load has priority; the counter saturates at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {PER_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (ena && (cnt_r != {PER_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(PER_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {PER_W{1'b0}});

endmodule

// File: rtl/step_dir_generator.sv
// Converts a move command into CP step pulses and a CCW direction level, with
// direction setup time before the first pulse and a sticky, pulse-completing abort.
module step_dir_generator
    import step_dir_generator_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PER_W     = PER_W_DEF,
    parameter int DIR_SETUP = DIR_SETUP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [PER_W-1:0] cmd_half,
    input  logic             abort,
    output logic             cp,
    output logic             ccw,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] steps_left
);

    localparam logic [PER_W-1:0] PER_ONE    = {{(PER_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PER_W-1:0] SETUP_LOAD = PER_W'(DIR_SETUP - 1);

    state_e           state_r, state_s;
    logic             cp_r, cp_s;
    logic             ccw_r, ccw_s;
    logic             done_r, done_s;
    logic             abort_r, abort_s;
    logic [CNT_W-1:0] steps_left_r, steps_left_s;
    logic [PER_W-1:0] half_r, half_s;
    logic [PER_W-1:0] half_eff_s;
    logic [PER_W-1:0] tmr_val_s;
    logic             tmr_load_s;
    logic             tmr_zero_s;
    logic             accept_s;
    logic             abort_any_s;

    assign cmd_ready   = (state_r == ST_IDLE) && !rst;
    assign accept_s    = cmd_valid && cmd_ready;
    assign abort_any_s = abort_r || abort;
    assign half_eff_s  = (cmd_half == {PER_W{1'b0}}) ? PER_ONE : cmd_half;

    step_dir_generator_phase_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .ena      (state_r != ST_IDLE),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Next-state and output decode; every phase change reloads the shared timer.
    always_comb begin
        state_s      = state_r;
        cp_s         = cp_r;
        ccw_s        = ccw_r;
        done_s       = 1'b0;
        abort_s      = abort_any_s;
        steps_left_s = steps_left_r;
        half_s       = half_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = half_r - PER_ONE;
        case (state_r)
            ST_IDLE: begin
                abort_s = 1'b0;
                if (accept_s) begin
                    half_s       = half_eff_s;
                    steps_left_s = cmd_steps;
                    if (cmd_steps == {CNT_W{1'b0}}) begin
                        done_s = 1'b1;
                    end else if (cmd_dir == ccw_r) begin
                        state_s      = ST_HIGH;
                        cp_s         = 1'b1;
                        steps_left_s = cmd_steps - CNT_ONE;
                        tmr_load_s   = 1'b1;
                        tmr_val_s    = half_eff_s - PER_ONE;
                    end else begin
                        state_s    = ST_SETUP;
                        ccw_s      = cmd_dir;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = SETUP_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort_any_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    abort_s = 1'b0;
                end else if (tmr_zero_s) begin
                    state_s      = ST_HIGH;
                    cp_s         = 1'b1;
                    steps_left_s = steps_left_r - CNT_ONE;
                    tmr_load_s   = 1'b1;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_HIGH: begin
                if (tmr_zero_s) begin
                    state_s    = ST_LOW;
                    cp_s       = 1'b0;
                    tmr_load_s = 1'b1;
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_LOW: begin
                // A pending abort is honoured only once the low phase has run its full length.
                if (tmr_zero_s && ((steps_left_r == {CNT_W{1'b0}}) || abort_any_s)) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    abort_s = 1'b0;
                end else if (tmr_zero_s) begin
                    state_s      = ST_HIGH;
                    cp_s         = 1'b1;
                    steps_left_s = steps_left_r - CNT_ONE;
                    tmr_load_s   = 1'b1;
                end else begin
                    state_s = ST_LOW;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cp_s    = 1'b0;
                abort_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops CP at once and suppresses DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cp_r         <= 1'b0;
            ccw_r        <= 1'b0;
            done_r       <= 1'b0;
            abort_r      <= 1'b0;
            steps_left_r <= {CNT_W{1'b0}};
            half_r       <= PER_ONE;
        end else begin
            state_r      <= state_s;
            cp_r         <= cp_s;
            ccw_r        <= ccw_s;
            done_r       <= done_s;
            abort_r      <= abort_s;
            steps_left_r <= steps_left_s;
            half_r       <= half_s;
        end
    end

    assign cp         = cp_r;
    assign ccw        = ccw_r;
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;
    assign steps_left = steps_left_r;

endmodule
